// File: rtl/fb_pkg.sv
// Shared defaults for the frame-buffer read side: bus widths, 640x480 timing, scan FSM states.
package fb_pkg;

  localparam int ADDR_W_DEF   = 20;
  localparam int DATA_W_DEF   = 8;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_timing_gen.sv
// Raster position counters with active-area, raw sync and frame-boundary flags.
// Counters sit at (0,0) whenever i_run is low, so a scan always begins at the frame origin.
module display_timing_gen
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
)(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_active,
  output logic o_hsync_act,
  output logic o_vsync_act,
  output logic o_frame_first,
  output logic o_frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare count so the exclusive sync-end bounds always fit the counter width
  localparam int HW = cnt_width(H_TOTAL + 1);
  localparam int VW = cnt_width(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_hcnt == H_LAST);
  assign w_v_last = (r_vcnt == V_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_run) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_last) begin
      r_hcnt <= '0;
      r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  assign o_active      = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign o_hsync_act   = (r_hcnt >= H_SYNC_BEG) && (r_hcnt < H_SYNC_END);
  assign o_vsync_act   = (r_vcnt >= V_SYNC_BEG) && (r_vcnt < V_SYNC_END);
  assign o_frame_first = (r_hcnt == '0) && (r_vcnt == '0);
  assign o_frame_end   = w_h_last && w_v_last;

endmodule

// File: rtl/fb_scan_reader.sv
// Frame-buffer read scanner: raster-order RAM reads with syncs/blanking aligned to the returned data.
//   IDLE | outputs parked at reset values, waiting for Enable
//   SCAN | counters running, one read per active pixel; leaves only at frame end with Enable low
module fb_scan_reader
  import fb_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                H_ACTIVE  = H_ACTIVE_DEF,
  parameter int                H_FP      = H_FP_DEF,
  parameter int                H_SYNC    = H_SYNC_DEF,
  parameter int                H_BP      = H_BP_DEF,
  parameter int                V_ACTIVE  = V_ACTIVE_DEF,
  parameter int                V_FP      = V_FP_DEF,
  parameter int                V_SYNC    = V_SYNC_DEF,
  parameter int                V_BP      = V_BP_DEF,
  parameter bit                SYNC_POL  = 1'b0
)(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  output logic [DATA_W-1:0] o_pixel,
  output logic              o_pixel_valid,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_frame_start,
  output logic              o_busy
);

  scan_state_e r_state;
  scan_state_e w_state_nxt;
  logic        w_scan;

  logic w_active;
  logic w_hsync_act;
  logic w_vsync_act;
  logic w_frame_first;
  logic w_frame_end;

  logic [ADDR_W-1:0] r_offset;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_en;
  logic              r_hs0;
  logic              r_vs0;
  logic              r_fs0;

  logic              r_act1;
  logic              r_hs1;
  logic              r_vs1;
  logic              r_fs1;

  logic [DATA_W-1:0] r_pixel;
  logic              r_pixel_valid;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_frame_start;

  display_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_run         (w_scan),
    .o_active      (w_active),
    .o_hsync_act   (w_hsync_act),
    .o_vsync_act   (w_vsync_act),
    .o_frame_first (w_frame_first),
    .o_frame_end   (w_frame_end)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_enable) w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_frame_end && !i_enable) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_scan = (r_state == ST_SCAN);
    o_busy = w_scan;
  end

  // Read stage: address/strobe for the current raster position; address holds through blanking
  always_ff @(posedge i_clk) begin
    if (i_reset || !w_scan) begin
      r_offset  <= '0;
      r_rd_addr <= BASE_ADDR;
      r_rd_en   <= 1'b0;
      r_hs0     <= 1'b0;
      r_vs0     <= 1'b0;
      r_fs0     <= 1'b0;
    end else begin
      r_rd_en <= w_active;
      r_hs0   <= w_hsync_act;
      r_vs0   <= w_vsync_act;
      r_fs0   <= w_frame_first;
      if (w_active) begin
        r_rd_addr <= BASE_ADDR + r_offset;
      end
      if (w_frame_end) begin
        r_offset <= '0;
      end else if (w_active) begin
        r_offset <= r_offset + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_act1 <= 1'b0;
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
      r_fs1  <= 1'b0;
    end else begin
      r_act1 <= r_rd_en;
      r_hs1  <= r_hs0;
      r_vs1  <= r_vs0;
      r_fs1  <= r_fs0;
    end
  end

  // Output stage captures RAM data the cycle it becomes valid
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pixel       <= '0;
      r_pixel_valid <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_pixel       <= r_act1 ? i_rd_data : '0;
      r_pixel_valid <= r_act1;
      r_hsync       <= r_hs1 ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= r_vs1 ? SYNC_POL : ~SYNC_POL;
      r_frame_start <= r_fs1;
    end
  end

  assign o_rd_addr     = r_rd_addr;
  assign o_rd_en       = r_rd_en;
  assign o_pixel       = r_pixel;
  assign o_pixel_valid = r_pixel_valid;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader: two instances (origin 0 / active-low syncs, origin 0xFFFFE / active-high)
// checked every cycle against a raster-index model, plus directed literal expectations.
module tb_fb_scan_reader;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int TOT = HT * VT;
  localparam int AW = 20;
  localparam int DW = 8;
  localparam logic [AW-1:0] BASE0 = 20'h00000;
  localparam logic [AW-1:0] BASE1 = 20'hFFFFE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] rdata0 = '0, rdata1 = '0;
  logic [AW-1:0] raddr0, raddr1;
  logic          ren0, ren1;
  logic [DW-1:0] pix0, pix1;
  logic          pv0, pv1, hs0, hs1, vs0, vs1, fs0, fs1, busy0, busy1;

  fb_scan_reader #(
    .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE0),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut0 (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_rd_data(rdata0),
    .o_rd_addr(raddr0), .o_rd_en(ren0), .o_pixel(pix0), .o_pixel_valid(pv0),
    .o_hsync(hs0), .o_vsync(vs0), .o_frame_start(fs0), .o_busy(busy0)
  );

  fb_scan_reader #(
    .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE1),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
  ) dut1 (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_rd_data(rdata1),
    .o_rd_addr(raddr1), .o_rd_en(ren1), .o_pixel(pix1), .o_pixel_valid(pv1),
    .o_hsync(hs1), .o_vsync(vs1), .o_frame_start(fs1), .o_busy(busy1)
  );

  // RAM read port: contents equal the low address byte, data one cycle after the strobe
  always @(posedge clk) begin
    if (ren0) rdata0 <= raddr0[7:0];
    if (ren1) rdata1 <= raddr1[7:0];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  // ---------------- behavioural model: scan position as a linear raster index ----------------
  typedef struct {
    bit scan;
    int idx;
  } ent_t;

  ent_t          hist[3];   // hist[0]: read stage, hist[2]: output stage
  bit            m_scan = 1'b0;
  int            m_idx  = 0;
  bit            m_live = 1'b0;
  logic [AW-1:0] m_addr0 = BASE0;
  logic [AW-1:0] m_addr1 = BASE1;

  function automatic int hpos(input ent_t e); return e.idx % HT; endfunction
  function automatic int vpos(input ent_t e); return e.idx / HT; endfunction
  function automatic bit e_active(input ent_t e);
    return e.scan && (hpos(e) < HA) && (vpos(e) < VA);
  endfunction
  function automatic bit e_hs(input ent_t e);
    return e.scan && (hpos(e) >= HA + HF) && (hpos(e) < HA + HF + HS);
  endfunction
  function automatic bit e_vs(input ent_t e);
    return e.scan && (vpos(e) >= VA + VF) && (vpos(e) < VA + VF + VS);
  endfunction
  function automatic logic [AW-1:0] e_addr(input ent_t e, input logic [AW-1:0] base);
    return base + AW'(vpos(e) * HA + hpos(e));
  endfunction
  function automatic logic lvl(input bit act, input bit pol);
    return act ? pol : !pol;
  endfunction

  always @(posedge clk) begin : model
    ent_t e;
    if (rst) begin
      m_scan = 1'b0;
      m_idx  = 0;
      for (int i = 0; i < 3; i++) hist[i] = '{scan: 1'b0, idx: 0};
      m_addr0 = BASE0;
      m_addr1 = BASE1;
      m_live  = 1'b1;
    end else begin
      e.scan = m_scan;
      e.idx  = m_idx;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = e;
      if (!e.scan) begin
        m_addr0 = BASE0;
        m_addr1 = BASE1;
      end else if (e_active(e)) begin
        m_addr0 = e_addr(e, BASE0);
        m_addr1 = e_addr(e, BASE1);
      end
      if (m_scan) begin
        if (m_idx == TOT - 1) begin
          m_idx  = 0;
          m_scan = en;
        end else begin
          m_idx++;
        end
      end else if (en) begin
        m_scan = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : compare
    ent_t          o;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] p0, p1;
    o  = hist[2];
    a0 = e_addr(o, BASE0);
    a1 = e_addr(o, BASE1);
    p0 = e_active(o) ? a0[7:0] : '0;
    p1 = e_active(o) ? a1[7:0] : '0;
    if (m_live) begin
      chk("rd_en0",  32'(ren0),   32'(e_active(hist[0])));
      chk("rd_en1",  32'(ren1),   32'(e_active(hist[0])));
      chk("rd_addr0", 32'(raddr0), 32'(m_addr0));
      chk("rd_addr1", 32'(raddr1), 32'(m_addr1));
      chk("pixel0",  32'(pix0),   32'(p0));
      chk("pixel1",  32'(pix1),   32'(p1));
      chk("valid0",  32'(pv0),    32'(e_active(o)));
      chk("valid1",  32'(pv1),    32'(e_active(o)));
      chk("hsync0",  32'(hs0),    32'(lvl(e_hs(o), 1'b0)));
      chk("hsync1",  32'(hs1),    32'(lvl(e_hs(o), 1'b1)));
      chk("vsync0",  32'(vs0),    32'(lvl(e_vs(o), 1'b0)));
      chk("vsync1",  32'(vs1),    32'(lvl(e_vs(o), 1'b1)));
      chk("fstart0", 32'(fs0),    32'(o.scan && o.idx == 0));
      chk("fstart1", 32'(fs1),    32'(o.scan && o.idx == 0));
      chk("busy0",   32'(busy0),  32'(m_scan));
      chk("busy1",   32'(busy1),  32'(m_scan));
    end
  end

  // ---------------- stimulus and literal expectations ----------------
  logic [AW-1:0] cap0[12], cap1[12];
  int n, gap, last_c, found, reads, cyc, hs_low, vs_low, nvalid, sum0, sum1, nfs;

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hsync0", 32'(hs0), 32'd1);
    chk("rst_vsync0", 32'(vs0), 32'd1);
    chk("rst_hsync1", 32'(hs1), 32'd0);
    chk("rst_busy0",  32'(busy0), 32'd0);
    chk("rst_rd_en0", 32'(ren0), 32'd0);
    chk("rst_addr1",  32'(raddr1), 32'hFFFFE);
    rst = 1'b0;

    // first frame: read order and per-line gap
    n = 0; gap = 0; last_c = 0;
    for (int c = 0; c < 80 && n < 12; c++) begin
      @(negedge clk);
      if (ren0) begin
        cap0[n] = raddr0;
        cap1[n] = raddr1;
        if (n == 4) gap = c - last_c;
        last_c = c;
        n++;
      end
    end
    chk("frame1_reads", 32'(n), 32'd12);
    chk("line_gap", 32'(gap), 32'd5);
    for (int i = 0; i < 12; i++) begin
      chk("addr_seq0", 32'(cap0[i]), 32'(i));
      chk("addr_seq1", 32'(cap1[i]), 32'((32'hFFFFE + 32'(i)) & 32'hFFFFF));
    end

    // full-frame window aligned to a FrameStart
    found = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (fs0) begin found = 1; break; end
    end
    chk("fs_seen", 32'(found), 32'd1);
    chk("fs_pixel0", 32'(pix0), 32'd0);
    chk("fs_valid0", 32'(pv0), 32'd1);
    chk("fs_pixel1", 32'(pix1), 32'hFE);
    hs_low = 0; vs_low = 0; nvalid = 0; sum0 = 0; sum1 = 0; nfs = 0;
    for (int c = 0; c < TOT; c++) begin
      if (c != 0) @(negedge clk);
      if (!hs0) hs_low++;
      if (!vs0) vs_low++;
      if (fs0) nfs++;
      if (pv0) begin nvalid++; sum0 += int'(pix0); sum1 += int'(pix1); end
    end
    @(negedge clk);
    chk("hsync_low_cycles", 32'(hs_low), 32'd12);
    chk("vsync_low_cycles", 32'(vs_low), 32'd8);
    chk("valid_per_frame", 32'(nvalid), 32'd12);
    chk("pixel_sum0", 32'(sum0), 32'd66);
    chk("pixel_sum1", 32'(sum1), 32'd554);
    chk("fs_per_frame", 32'(nfs), 32'd1);
    chk("fs_period", 32'(fs0), 32'd1);

    // Enable dropped on line 1: frame still completes
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (m_scan && m_idx == 0) begin found = 1; break; end
    end
    chk("origin_found", 32'(found), 32'd1);
    reads = 0; cyc = 0;
    for (int c = 0; c < 120; c++) begin
      if (ren0) reads++;
      if (m_idx == HT) en = 1'b0;
      if (!busy0) begin cyc = c; break; end
      @(negedge clk);
    end
    chk("drop_reads", 32'(reads), 32'd12);
    chk("drop_busy_fall", 32'(cyc), 32'd48);
    reads = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ren0) reads++;
    end
    chk("idle_no_reads", 32'(reads), 32'd0);

    // reset mid-frame at vcnt=2, hcnt=1
    en = 1'b1;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (m_scan && m_idx == 2 * HT + 1) begin found = 1; break; end
    end
    chk("reset_point_found", 32'(found), 32'd1);
    chk("pre_reset_addr0", 32'(raddr0), 32'd8);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rd_en0", 32'(ren0), 32'd0);
    chk("midrst_addr0", 32'(raddr0), 32'd0);
    chk("midrst_busy0", 32'(busy0), 32'd0);
    rst = 1'b0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ren0) begin found = 1; break; end
    end
    chk("restart_read", 32'(found), 32'd1);
    chk("restart_addr0", 32'(raddr0), 32'd0);
    chk("restart_addr1", 32'(raddr1), 32'hFFFFE);

    // randomized enable with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 4) en = ~en;
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    en  = 1'b0;
    repeat (2 * TOT) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
